lcd_panel_receiver: RTL and testbench
=====================================

Name: lcd_panel_receiver

Overview:
- Behavioural-synthesizable model of the DMG LCD panel: the receiving end of the video-control/LCD-driver pin interface (CPG, CPL, CP, ST, LD1:0).
- Samples the pins with the system clock, rebuilds pixel X/Y coordinates, and emits one write per pixel into a bench-side frame buffer.
- Also reports line/frame boundaries and protocol errors, so testbenches can compare rendered frames against golden images.

Parameters:
- WIDTH, 160, visible pixels per line.
- HEIGHT, 144, visible lines per frame.
- SYNC_STAGES, 2, synchronizer flops per input pin (minimum 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- nreset  input  1  synchronous, active-low reset.
- pin_cpg  input  1  frame-start marker; qualified at CPL rise.
- pin_cpl  input  1  line latch; rising edge ends the current line.
- pin_cp  input  1  pixel clock; data is taken on the falling edge.
- pin_st  input  1  horizontal sync; sampled only for error check.
- pin_ld  input  2  pixel data {LD1,LD0}.
- clr_err  input  1  clears the sticky error flags.
- px_valid  output  1  one-clock pixel write strobe.
- px_x  output  8  pixel column.
- px_y  output  8  pixel row.
- px_data  output  2  pixel shade.
- line_done  output  1  one-clock pulse at the end of a line that carried pixels.
- line_len  output  8  pixel count of the last completed line.
- frame_done  output  1  one-clock pulse when a new frame starts after a received frame.
- frame_cnt  output  8  completed frames; wraps 255->0.
- err_overrun  output  1  sticky: pixel with x>=WIDTH or y>=HEIGHT.
- err_short  output  1  sticky: line ended with 0<x<WIDTH.
- err_st  output  1  sticky: ST high while a CP fall is accepted.

Behaviour:
- Reset, synchronous on nreset=0 at a clk rise:
  - every output is 0; state is IDLE; x=0, y=0; synchronizers are cleared to 0.
  - Reset mid-line or mid-frame abandons all progress and fires no pulses.
- Sampling and edge detection:
  - Each pin passes through SYNC_STAGES flops, plus one history flop for edge detection.
  - cp_fall = prev & ~cur; cpl_rise = ~prev & cur.
  - pin_ld is delayed the same depth as pin_cp, so data and edge stay aligned.
  - Latency: px_valid is registered and asserts SYNC_STAGES+1 clocks after the pin-level CP fall.
- States:
  - IDLE: CP edges are ignored. cpl_rise with cpg=1 -> ACTIVE, x=0, y=0, no pulses.
  - ACTIVE: pixel and line rules below.
- Pixel, on cp_fall in ACTIVE:
  - If x<WIDTH and y<HEIGHT: px_valid=1, px_x=x, px_y=y, px_data=ld.
  - Otherwise: no write, err_overrun<=1.
  - Either way x<=x+1, saturating at 255.
  - If st=1 at the same time, err_st<=1.
- Line, on cpl_rise in ACTIVE:
  - If x!=0: line_done=1, line_len=x.
  - If 0<x<WIDTH: err_short<=1. Blank lines (x=0, vblank) do not count as short.
  - Then x<=0.
  - If cpg=1: y<=0, frame_done=1, frame_cnt<=frame_cnt+1 (mod 256).
  - Else: y<=y+1, saturating at 255.
- Simultaneous cp_fall and cpl_rise in the same clock: the pixel is handled first with the old x/y and is counted in line_len; the line rule then applies.
- Output registers: px_x/px_y/px_data/line_len hold their last values between strobes.
- clr_err=1 clears all three sticky flags. If an error event occurs in the same clock as clr_err, the set wins.
- frame_cnt and the error flags are cleared only by reset (errors also by clr_err); they are not cleared by going back to IDLE.

Decomposition:
- Package lcd_rx_pkg holds:
  - state enum {RX_IDLE, RX_ACTIVE};
  - constants LCD_WIDTH=160 and LCD_HEIGHT=144, used as the parameter defaults;
  - the 2-bit shade type.
- One sub-module, lcd_pin_sync: a parameterised N-bit synchronizer that outputs the registered level plus rise/fall strobes. It is instantiated once over the bus {cpg, cpl, cp, st, ld[1:0]}.

Test Plan:
- Reset then full frame: CPL+CPG, then 144 lines of 160 CP falls with ld=line[1:0], then CPL+CPG -> 23040 px_valid, last write px_x=159/px_y=143; 144 line_done with line_len=160; frame_done=1 once; frame_cnt=1; no errors.
- Pre-sync activity: 50 CP falls and 3 CPL rises with cpg=0 straight after reset -> no px_valid, no pulses; state remains IDLE.
- Short line: 100 CP falls then CPL rise -> line_done, line_len=100, err_short=1; clr_err -> 0.
- Overrun: 161 CP falls in one line -> 160 writes, err_overrun=1, line_len=161. A pixel on line y=144 also sets err_overrun.
- Coincident edges: last CP fall and CPL rise reach the pins in the same clock -> px_valid for x=159, then line_done with line_len=160; next pixel written at x=0, y+1.
- Mid-frame reset: nreset=0 at line 70 -> all outputs 0; following CP falls are ignored until CPL+CPG; frame_cnt restarts from 0.

Source files
------------

// File: rtl/lcd_rx_pkg.sv
// Shared types and constants for the DMG LCD panel receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lcd_rx_pkg;

  localparam int LCD_WIDTH  = 160;
  localparam int LCD_HEIGHT = 144;

  typedef enum logic {
    RX_IDLE   = 1'b0,
    RX_ACTIVE = 1'b1
  } rx_state_e;

  typedef logic [1:0] shade_t;

  // Coordinate counters stop at 255 so a runaway line or frame cannot wrap
  // back into the visible area and overwrite good pixels.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lcd_pin_sync.sv
// N-bit pin synchronizer with level plus single-clock rise/fall strobes.
// Latency: level/strobes follow the pin by STAGES clocks.
// Backpressure: none; pins are sampled every clock.
//
// Ports:
//   clk_i, nreset_i   clock and synchronous active-low reset
//   d_i               raw asynchronous pin bus
//   level_o           synchronized level (last stage of the chain)
//   rise_o / fall_o   one-clock strobes derived against a history flop
module lcd_pin_sync #(
  parameter int N      = 6,
  parameter int STAGES = 2   // must be >= 2 for metastability settling
) (
  input  logic         clk_i,
  input  logic         nreset_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] level_o,
  output logic [N-1:0] rise_o,
  output logic [N-1:0] fall_o
);

  logic [N-1:0] sync_q [STAGES];
  logic [N-1:0] hist_q;

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = ~hist_q & level_o;
  assign fall_o  = hist_q & ~level_o;

endmodule

// File: rtl/lcd_panel_receiver.sv
// DMG LCD panel model: rebuilds pixel X/Y from CPG/CPL/CP/ST/LD pins.
// Latency: px_valid SYNC_STAGES+1 clocks after the pin-level CP fall.
// Backpressure: none; every accepted pixel is emitted as a one-clock strobe.
//
// Ports:
//   clk, nreset                      clock, synchronous active-low reset
//   pin_cpg/cpl/cp/st/ld             raw panel pins (asynchronous)
//   clr_err                          clears sticky error flags
//   px_valid/px_x/px_y/px_data       pixel write to the frame buffer
//   line_done/line_len               end-of-line pulse and pixel count
//   frame_done/frame_cnt             frame boundary pulse and counter
//   err_overrun/err_short/err_st     sticky protocol errors
module lcd_panel_receiver
  import lcd_rx_pkg::*;
#(
  parameter int WIDTH       = LCD_WIDTH,
  parameter int HEIGHT      = LCD_HEIGHT,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       pin_cpg,
  input  logic       pin_cpl,
  input  logic       pin_cp,
  input  logic       pin_st,
  input  logic [1:0] pin_ld,
  input  logic       clr_err,
  output logic       px_valid,
  output logic [7:0] px_x,
  output logic [7:0] px_y,
  output logic [1:0] px_data,
  output logic       line_done,
  output logic [7:0] line_len,
  output logic       frame_done,
  output logic [7:0] frame_cnt,
  output logic       err_overrun,
  output logic       err_short,
  output logic       err_st
);

  // Nine-bit bounds so the comparison against x/y never truncates.
  localparam logic [8:0] WIDTH_L  = 9'(WIDTH);
  localparam logic [8:0] HEIGHT_L = 9'(HEIGHT);

  // Bus order: {cpg, cpl, cp, st, ld[1:0]}; ld rides the same chain as cp
  // so the shade seen at a detected fall is the one present at the pin fall.
  logic [5:0] pin_lvl, pin_rise, pin_fall;

  lcd_pin_sync #(.N(6), .STAGES(SYNC_STAGES)) u_sync (
    .clk_i    (clk),
    .nreset_i (nreset),
    .d_i      ({pin_cpg, pin_cpl, pin_cp, pin_st, pin_ld}),
    .level_o  (pin_lvl),
    .rise_o   (pin_rise),
    .fall_o   (pin_fall)
  );

  logic   cpg_lvl, st_lvl, cpl_rise, cp_fall;
  shade_t ld_lvl;
  logic   unused_edges;

  assign cpg_lvl      = pin_lvl[5];
  assign st_lvl       = pin_lvl[2];
  assign ld_lvl       = pin_lvl[1:0];
  assign cpl_rise     = pin_rise[4];
  assign cp_fall      = pin_fall[3];
  assign unused_edges = ^{pin_lvl[4:3], pin_rise[5], pin_rise[3:0],
                          pin_fall[5:4], pin_fall[2:0]};

  rx_state_e state_q, state_d;
  logic [7:0] x_q, x_d, y_q, y_d, x_cur;
  logic       px_valid_q, px_valid_d;
  logic [7:0] px_x_q, px_x_d, px_y_q, px_y_d;
  shade_t     px_data_q, px_data_d;
  logic       line_done_q, line_done_d;
  logic [7:0] line_len_q, line_len_d;
  logic       frame_done_q, frame_done_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       err_overrun_q, err_overrun_d;
  logic       err_short_q, err_short_d;
  logic       err_st_q, err_st_d;

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    x_cur         = x_q;
    px_valid_d    = 1'b0;
    px_x_d        = px_x_q;
    px_y_d        = px_y_q;
    px_data_d     = px_data_q;
    line_done_d   = 1'b0;
    line_len_d    = line_len_q;
    frame_done_d  = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    // Clear first; any error event below overrides it in the same clock.
    err_overrun_d = err_overrun_q & ~clr_err;
    err_short_d   = err_short_q & ~clr_err;
    err_st_d      = err_st_q & ~clr_err;

    case (state_q)
      RX_IDLE: begin
        if (cpl_rise && cpg_lvl) begin
          state_d = RX_ACTIVE;
          x_d     = '0;
          y_d     = '0;
        end
      end
      RX_ACTIVE: begin
        // Pixel first with the old x/y, so a coincident CPL rise counts it.
        if (cp_fall) begin
          if (({1'b0, x_q} < WIDTH_L) && ({1'b0, y_q} < HEIGHT_L)) begin
            px_valid_d = 1'b1;
            px_x_d     = x_q;
            px_y_d     = y_q;
            px_data_d  = ld_lvl;
          end else begin
            err_overrun_d = 1'b1;
          end
          if (st_lvl) err_st_d = 1'b1;
          x_cur = sat_inc8(x_q);
        end
        x_d = x_cur;
        if (cpl_rise) begin
          if (x_cur != 8'd0) begin
            line_done_d = 1'b1;
            line_len_d  = x_cur;
            // Blank (vblank) lines carry no pixels and are never short.
            if ({1'b0, x_cur} < WIDTH_L) err_short_d = 1'b1;
          end
          x_d = '0;
          if (cpg_lvl) begin
            y_d          = '0;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 8'd1;
          end else begin
            y_d = sat_inc8(y_q);
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q       <= RX_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      px_valid_q    <= 1'b0;
      px_x_q        <= '0;
      px_y_q        <= '0;
      px_data_q     <= '0;
      line_done_q   <= 1'b0;
      line_len_q    <= '0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= '0;
      err_overrun_q <= 1'b0;
      err_short_q   <= 1'b0;
      err_st_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      px_valid_q    <= px_valid_d;
      px_x_q        <= px_x_d;
      px_y_q        <= px_y_d;
      px_data_q     <= px_data_d;
      line_done_q   <= line_done_d;
      line_len_q    <= line_len_d;
      frame_done_q  <= frame_done_d;
      frame_cnt_q   <= frame_cnt_d;
      err_overrun_q <= err_overrun_d;
      err_short_q   <= err_short_d;
      err_st_q      <= err_st_d;
    end
  end

  assign px_valid    = px_valid_q;
  assign px_x        = px_x_q;
  assign px_y        = px_y_q;
  assign px_data     = px_data_q;
  assign line_done   = line_done_q;
  assign line_len    = line_len_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_overrun = err_overrun_q;
  assign err_short   = err_short_q;
  assign err_st      = err_st_q;

endmodule

// File: tb/tb_lcd_panel_receiver.sv
// Testbench for lcd_panel_receiver: random pin traffic against a pin-event model.
// Latency: checks are taken after a fixed drain period.
// Backpressure: none.
module tb_lcd_panel_receiver;

  logic       clk = 1'b0;
  logic       nreset, pin_cpg, pin_cpl, pin_cp, pin_st, clr_err;
  logic [1:0] pin_ld;
  logic       px_valid, line_done, frame_done;
  logic [7:0] px_x, px_y, line_len, frame_cnt;
  logic [1:0] px_data;
  logic       err_overrun, err_short, err_st;

  lcd_panel_receiver dut (
    .clk(clk), .nreset(nreset), .pin_cpg(pin_cpg), .pin_cpl(pin_cpl),
    .pin_cp(pin_cp), .pin_st(pin_st), .pin_ld(pin_ld), .clr_err(clr_err),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_data(px_data),
    .line_done(line_done), .line_len(line_len), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .err_overrun(err_overrun), .err_short(err_short),
    .err_st(err_st)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model, advanced once per pin-level event.
  bit          m_active, m_ovr, m_short, m_st;
  int          m_x, m_y, m_fcnt, m_frames;
  logic [17:0] exp_px[$], got_px[$];
  logic [7:0]  exp_ln[$], got_ln[$];
  int          got_frames;

  wire [39:0] all_out = {px_valid, px_x, px_y, px_data, line_done, line_len,
                         frame_done, frame_cnt, err_overrun, err_short, err_st};

  always @(negedge clk) begin
    if (nreset === 1'b1) begin
      if (px_valid)   got_px.push_back({px_x, px_y, px_data});
      if (line_done)  got_ln.push_back(line_len);
      if (frame_done) got_frames++;
    end
  end

  function automatic void model_clear();
    m_active = 0; m_ovr = 0; m_short = 0; m_st = 0;
    m_x = 0; m_y = 0; m_fcnt = 0; m_frames = 0;
    exp_px.delete(); got_px.delete(); exp_ln.delete(); got_ln.delete();
    got_frames = 0;
  endfunction

  function automatic void model_pixel(input logic [1:0] ld, input logic st);
    if (!m_active) return;
    if (m_x < 160 && m_y < 144) exp_px.push_back({8'(m_x), 8'(m_y), ld});
    else m_ovr = 1;
    if (st) m_st = 1;
    if (m_x < 255) m_x++;
  endfunction

  function automatic void model_line(input logic cpg);
    if (!m_active) begin
      if (cpg) begin m_active = 1; m_x = 0; m_y = 0; end
      return;
    end
    if (m_x != 0) exp_ln.push_back(8'(m_x));
    if (m_x > 0 && m_x < 160) m_short = 1;
    m_x = 0;
    if (cpg) begin
      m_y = 0; m_frames++; m_fcnt = (m_fcnt + 1) % 256;
    end else if (m_y < 255) m_y++;
  endfunction

  function automatic int px_mism();
    int n = 0;
    if (got_px.size() != exp_px.size()) return -1;
    foreach (exp_px[i]) if (got_px[i] !== exp_px[i]) n++;
    return n;
  endfunction

  function automatic int ln_mism();
    int n = 0;
    if (got_ln.size() != exp_ln.size()) return -1;
    foreach (exp_ln[i]) if (got_ln[i] !== exp_ln[i]) n++;
    return n;
  endfunction

  task automatic step(input logic cpg, input logic cpl, input logic cp,
                      input logic st, input logic [1:0] ld);
    @(negedge clk);
    pin_cpg = cpg; pin_cpl = cpl; pin_cp = cp; pin_st = st; pin_ld = ld;
  endtask

  // CP high phase carries random ST/LD that must never be sampled.
  task automatic pixel(input logic [1:0] ld, input logic st);
    step(1'b0, 1'b0, 1'b1, 1'($urandom), 2'($urandom));
    step(1'b0, 1'b0, 1'b0, st, ld);
    model_pixel(ld, st);
  endtask

  task automatic line(input logic cpg);
    step(cpg, 1'b1, 1'b0, 1'b0, 2'($urandom));
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'($urandom));
    model_line(cpg);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    m_ovr = 0; m_short = 0; m_st = 0;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    nreset = 1'b0; clr_err = 1'b0;
    pin_cpg = 0; pin_cpl = 0; pin_cp = 0; pin_st = 0; pin_ld = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_reset();
    nreset = 1'b1;
    model_clear();
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    hold_reset();
    n_checks++;
    if (all_out !== 40'd0) $display("FAIL reset_outputs got=%h exp=0", all_out); else n_pass++;
    release_reset();
    settle();
    n_checks++;
    if (all_out !== 40'd0) $display("FAIL post_reset_idle got=%h exp=0", all_out); else n_pass++;
  endtask

  task automatic test_full_frame();
    logic [17:0] last;
    hold_reset(); release_reset();
    line(1'b1);
    for (int y = 0; y < 144; y++) begin
      for (int x = 0; x < 160; x++) pixel(2'(y), 1'b0);
      line(y == 143);
    end
    settle();
    n_checks++;
    if (got_px.size() !== 23040) $display("FAIL full_px_count got=%0d exp=23040", got_px.size()); else n_pass++;
    last = (got_px.size() > 0) ? got_px[$] : 18'h0;
    n_checks++;
    if (last !== {8'd159, 8'd143, 2'd3}) $display("FAIL full_last_px got=%h exp=%h", last, {8'd159, 8'd143, 2'd3}); else n_pass++;
    n_checks++;
    if (px_mism() !== 0) $display("FAIL full_px_stream mism=%0d exp=0", px_mism()); else n_pass++;
    n_checks++;
    if (got_ln.size() !== 144 || ln_mism() !== 0) $display("FAIL full_lines got=%0d mism=%0d exp=144/0", got_ln.size(), ln_mism()); else n_pass++;
    n_checks++;
    if (got_frames !== 1 || frame_cnt !== 8'd1) $display("FAIL full_frame got=%0d cnt=%0d exp=1/1", got_frames, frame_cnt); else n_pass++;
    n_checks++;
    if ({err_overrun, err_short, err_st} !== 3'b000) $display("FAIL full_errors got=%b exp=000", {err_overrun, err_short, err_st}); else n_pass++;
  endtask

  task automatic test_presync();
    hold_reset(); release_reset();
    for (int i = 0; i < 50; i++) pixel(2'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) line(1'b0);
    pixel(2'd3, 1'b0);
    settle();
    n_checks++;
    if (got_px.size() !== 0 || got_ln.size() !== 0 || got_frames !== 0)
      $display("FAIL presync_quiet got px=%0d ln=%0d fr=%0d exp=0/0/0", got_px.size(), got_ln.size(), got_frames);
    else n_pass++;
  endtask

  task automatic test_short_line();
    hold_reset(); release_reset();
    line(1'b1);
    for (int i = 0; i < 100; i++) pixel(2'($urandom), 1'b0);
    line(1'b0);
    settle();
    n_checks++;
    if (got_ln.size() !== 1 || line_len !== 8'd100) $display("FAIL short_len got=%0d n=%0d exp=100/1", line_len, got_ln.size()); else n_pass++;
    n_checks++;
    if (px_mism() !== 0) $display("FAIL short_px_stream mism=%0d exp=0", px_mism()); else n_pass++;
    n_checks++;
    if ({err_overrun, err_short, err_st} !== {m_ovr, m_short, m_st} || err_short !== 1'b1)
      $display("FAIL short_err got=%b exp=%b", {err_overrun, err_short, err_st}, {m_ovr, m_short, m_st});
    else n_pass++;
    pulse_clr();
    settle();
    n_checks++;
    if (err_short !== 1'b0) $display("FAIL short_clr got=%b exp=0", err_short); else n_pass++;
  endtask

  task automatic test_st_error();
    logic [1:0] ld;
    for (int i = 0; i < 20; i++) pixel(2'($urandom), 1'b0);
    settle();
    n_checks++;
    if (err_st !== 1'b0) $display("FAIL st_high_phase got=%b exp=0", err_st); else n_pass++;
    // ST at the fall, with clr_err landing on the very clock the flag sets.
    ld = 2'($urandom);
    step(1'b0, 1'b0, 1'b1, 1'b0, ld);
    step(1'b0, 1'b0, 1'b0, 1'b1, ld);
    model_pixel(ld, 1'b1);
    @(negedge clk); pin_st = 1'b0;
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    m_ovr = 0; m_short = 0;
    settle();
    n_checks++;
    if (err_st !== 1'b1) $display("FAIL st_set_wins got=%b exp=1", err_st); else n_pass++;
    n_checks++;
    if (px_mism() !== 0) $display("FAIL st_px_stream mism=%0d exp=0", px_mism()); else n_pass++;
  endtask

  task automatic test_overrun();
    hold_reset(); release_reset();
    line(1'b1);
    for (int i = 0; i < 161; i++) pixel(2'($urandom), 1'b0);
    line(1'b0);
    settle();
    n_checks++;
    if (got_px.size() !== 160 || px_mism() !== 0) $display("FAIL ovr_writes got=%0d mism=%0d exp=160/0", got_px.size(), px_mism()); else n_pass++;
    n_checks++;
    if (line_len !== 8'd161 || err_overrun !== 1'b1 || err_short !== 1'b0)
      $display("FAIL ovr_line got len=%0d ovr=%b short=%b exp=161/1/0", line_len, err_overrun, err_short);
    else n_pass++;
    pulse_clr();
    line(1'b1);
    for (int i = 0; i < 144; i++) line(1'b0);
    pixel(2'd1, 1'b0);
    settle();
    n_checks++;
    if (got_px.size() !== 160 || err_overrun !== m_ovr || err_overrun !== 1'b1)
      $display("FAIL ovr_row144 got px=%0d ovr=%b exp=160/1", got_px.size(), err_overrun);
    else n_pass++;
    n_checks++;
    if (got_frames !== m_frames || frame_cnt !== 8'(m_fcnt)) $display("FAIL ovr_frames got=%0d cnt=%0d exp=%0d", got_frames, frame_cnt, m_fcnt); else n_pass++;
  endtask

  task automatic test_coincident();
    logic [1:0] ld;
    hold_reset(); release_reset();
    line(1'b1);
    for (int i = 0; i < 159; i++) pixel(2'($urandom), 1'b0);
    ld = 2'($urandom);
    step(1'b0, 1'b0, 1'b1, 1'b0, ld);
    step(1'b0, 1'b1, 1'b0, 1'b0, ld);
    model_pixel(ld, 1'b0);
    model_line(1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, ld);
    pixel(2'($urandom), 1'b0);
    settle();
    n_checks++;
    if (got_px.size() !== 161 || px_mism() !== 0) $display("FAIL coin_px got=%0d mism=%0d exp=161/0", got_px.size(), px_mism()); else n_pass++;
    n_checks++;
    if (got_px.size() < 161 || got_px[159] !== {8'd159, 8'd0, ld} || got_px[160][17:2] !== {8'd0, 8'd1})
      $display("FAIL coin_xy got n=%0d exp last=%h then x0/y1", got_px.size(), {8'd159, 8'd0, ld});
    else n_pass++;
    n_checks++;
    if (got_ln.size() !== 1 || line_len !== 8'd160 || err_short !== 1'b0)
      $display("FAIL coin_line got len=%0d n=%0d short=%b exp=160/1/0", line_len, got_ln.size(), err_short);
    else n_pass++;
  endtask

  task automatic test_mid_frame_reset();
    hold_reset(); release_reset();
    line(1'b1); line(1'b1);
    for (int y = 0; y < 70; y++) begin
      for (int x = 0; x < 8; x++) pixel(2'($urandom), 1'b0);
      line(1'b0);
    end
    for (int x = 0; x < 5; x++) pixel(2'($urandom), 1'b0);
    n_checks++;
    if (frame_cnt !== 8'd1 || ln_mism() !== 0) $display("FAIL mid_pre got cnt=%0d mism=%0d exp=1/0", frame_cnt, ln_mism()); else n_pass++;
    @(negedge clk); nreset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (all_out !== 40'd0) $display("FAIL mid_reset_out got=%h exp=0", all_out); else n_pass++;
    release_reset();
    for (int x = 0; x < 20; x++) pixel(2'($urandom), 1'b0);
    settle();
    n_checks++;
    if (got_px.size() !== 0 || frame_cnt !== 8'd0 || got_frames !== 0)
      $display("FAIL mid_ignored got px=%0d cnt=%0d fr=%0d exp=0", got_px.size(), frame_cnt, got_frames);
    else n_pass++;
    line(1'b1);
    for (int x = 0; x < 8; x++) pixel(2'($urandom), 1'b0);
    line(1'b1);
    settle();
    n_checks++;
    if (frame_cnt !== 8'd1 || got_frames !== 1 || px_mism() !== 0 || line_len !== 8'd8)
      $display("FAIL mid_restart got cnt=%0d fr=%0d mism=%0d len=%0d exp=1/1/0/8", frame_cnt, got_frames, px_mism(), line_len);
    else n_pass++;
  endtask

  initial begin
    nreset = 1'b0; clr_err = 1'b0;
    pin_cpg = 0; pin_cpl = 0; pin_cp = 0; pin_st = 0; pin_ld = 0;
    test_reset();
    test_full_frame();
    test_presync();
    test_short_line();
    test_st_error();
    test_overrun();
    test_coincident();
    test_mid_frame_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
